// File: rtl/fir_decim_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fir_decim_sequencer
// Brief    : Time-shares one MAC across all taps of a decimating FIR stage.
// Revision : 1.0 - initial release
// ============================================================================
module fir_decim_sequencer #(
  parameter int TAPS       = 32,
  parameter int DECIM      = 8,
  parameter int DATA_WIDTH = 32,
  parameter int BITS       = 10
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   in_dout,
  input  logic                    in_empty,
  output logic                    in_rd_en,
  output logic [$clog2(TAPS)-1:0] coeff_addr,
  input  logic [DATA_WIDTH-1:0]   coeff_data,
  input  logic                    out_full,
  output logic                    out_wr_en,
  output logic [DATA_WIDTH-1:0]   out_din,
  output logic                    busy
);

  localparam int AW    = $clog2(TAPS);
  localparam int CW    = $clog2(DECIM + 1);
  localparam int PW    = 2 * DATA_WIDTH;
  localparam int ACC_W = PW + AW;
  localparam logic [ACC_W-1:0] RND_BIAS = {{(ACC_W - BITS){1'b0}}, {BITS{1'b1}}};

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_MAC   = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t                       state_q, state_d;
  logic [CW-1:0]                load_cnt_q, load_cnt_d;
  logic [AW-1:0]                tap_cnt_q, tap_cnt_d;
  logic signed [ACC_W-1:0]      acc_q, acc_d;
  logic [DATA_WIDTH-1:0]        out_din_q, out_din_d;
  logic signed [DATA_WIDTH-1:0] hist_q [TAPS];
  logic signed [DATA_WIDTH-1:0] hist_d [TAPS];

  logic signed [PW-1:0]         coeff_ext, hist_ext, prod;
  logic signed [ACC_W-1:0]      sum, sum_adj;

  assign in_rd_en   = (state_q == S_LOAD) && !in_empty && !reset;
  assign out_wr_en  = (state_q == S_WRITE) && !out_full && !reset;
  assign busy       = ((state_q == S_MAC) || (state_q == S_WRITE)) && !reset;
  assign coeff_addr = ((state_q == S_MAC) && !reset) ? tap_cnt_q : '0;
  assign out_din    = out_din_q;

  // Bias negative sums before the arithmetic shift so the divide truncates toward zero.
  always_comb begin
    coeff_ext = $signed({{DATA_WIDTH{coeff_data[DATA_WIDTH-1]}}, coeff_data});
    hist_ext  = $signed({{DATA_WIDTH{hist_q[tap_cnt_q][DATA_WIDTH-1]}}, hist_q[tap_cnt_q]});
    prod      = coeff_ext * hist_ext;
    sum       = acc_q + $signed({{AW{prod[PW-1]}}, prod});
    sum_adj   = sum[ACC_W-1] ? (sum + $signed(RND_BIAS)) : sum;
  end

  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    tap_cnt_d  = tap_cnt_q;
    acc_d      = acc_q;
    out_din_d  = out_din_q;
    hist_d     = hist_q;
    case (state_q)
      S_LOAD: begin
        if (in_rd_en) begin
          for (int k = TAPS - 1; k >= 1; k--) begin
            hist_d[k] = hist_q[k-1];
          end
          hist_d[0] = $signed(in_dout);
          if (load_cnt_q == CW'(DECIM - 1)) begin
            load_cnt_d = '0;
            tap_cnt_d  = '0;
            acc_d      = '0;
            state_d    = S_MAC;
          end else begin
            load_cnt_d = load_cnt_q + 1'b1;
          end
        end
      end
      S_MAC: begin
        if (tap_cnt_q == AW'(TAPS - 1)) begin
          out_din_d = DATA_WIDTH'(sum_adj >>> BITS);
          state_d   = S_WRITE;
        end else begin
          acc_d     = sum;
          tap_cnt_d = tap_cnt_q + 1'b1;
        end
      end
      S_WRITE: begin
        if (out_wr_en) begin
          load_cnt_d = '0;
          state_d    = S_LOAD;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_LOAD;
      load_cnt_q <= '0;
      tap_cnt_q  <= '0;
      acc_q      <= '0;
      out_din_q  <= '0;
      for (int k = 0; k < TAPS; k++) begin
        hist_q[k] <= '0;
      end
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      tap_cnt_q  <= tap_cnt_d;
      acc_q      <= acc_d;
      out_din_q  <= out_din_d;
      for (int k = 0; k < TAPS; k++) begin
        hist_q[k] <= hist_d[k];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fir_decim_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_decim_sequencer
// Brief    : Directed and table-driven checks for fir_decim_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_decim_sequencer;

  localparam int DW      = 32;
  localparam int TAPS_A  = 32;
  localparam int DECIM_A = 8;
  localparam int TAPS_B  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: audio decimator configuration
  logic [DW-1:0] a_in_dout = '0;
  logic          a_in_empty = 1'b1;
  logic          a_in_rd_en;
  logic [4:0]    a_coeff_addr;
  logic [DW-1:0] a_coeff_data;
  logic          a_out_full = 1'b0;
  logic          a_out_wr_en;
  logic [DW-1:0] a_out_din;
  logic          a_busy;
  int            coeff_a [TAPS_A];
  assign a_coeff_data = coeff_a[a_coeff_addr];

  // Instance B: DECIM=1 channel filter
  logic [DW-1:0] b_in_dout = '0;
  logic          b_in_empty = 1'b1;
  logic          b_in_rd_en;
  logic [1:0]    b_coeff_addr;
  logic [DW-1:0] b_coeff_data;
  logic          b_out_full = 1'b0;
  logic          b_out_wr_en;
  logic [DW-1:0] b_out_din;
  logic          b_busy;
  int            coeff_b [TAPS_B];
  assign b_coeff_data = coeff_b[b_coeff_addr];

  fir_decim_sequencer #(.TAPS(TAPS_A), .DECIM(DECIM_A), .DATA_WIDTH(DW), .BITS(10)) dut_a (
    .clock(clk), .reset(rst), .in_dout(a_in_dout), .in_empty(a_in_empty),
    .in_rd_en(a_in_rd_en), .coeff_addr(a_coeff_addr), .coeff_data(a_coeff_data),
    .out_full(a_out_full), .out_wr_en(a_out_wr_en), .out_din(a_out_din), .busy(a_busy)
  );

  fir_decim_sequencer #(.TAPS(TAPS_B), .DECIM(1), .DATA_WIDTH(DW), .BITS(10)) dut_b (
    .clock(clk), .reset(rst), .in_dout(b_in_dout), .in_empty(b_in_empty),
    .in_rd_en(b_in_rd_en), .coeff_addr(b_coeff_addr), .coeff_data(b_coeff_data),
    .out_full(b_out_full), .out_wr_en(b_out_wr_en), .out_din(b_out_din), .busy(b_busy)
  );

  typedef struct {
    int sample;
    int expected;
  } vec_t;

  int     checks = 0;
  int     errors = 0;
  int     a_src [$];
  int     a_got [$];
  longint a_exp [$];
  longint m_hist [TAPS_A];
  int     m_cnt = 0;
  int     cyc = 0;
  int     last_pop_cyc = 0;
  int     last_push_cyc = 0;
  bit     rand_empty = 1'b0;
  bit     a_full_next = 1'b0;
  bit     b_have = 1'b0;

  task automatic check(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < TAPS_A; k++) m_hist[k] = 0;
    m_cnt = 0;
    a_src.delete();
    a_got.delete();
    a_exp.delete();
  endtask

  // Reference FIR: sliding window, one output per DECIM_A pops, truncating divide.
  task automatic model_pop(input int s);
    longint acc;
    for (int k = TAPS_A - 1; k >= 1; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = s;
    m_cnt++;
    if (m_cnt == DECIM_A) begin
      m_cnt = 0;
      acc = 0;
      for (int k = 0; k < TAPS_A; k++) acc += longint'(coeff_a[k]) * m_hist[k];
      a_exp.push_back(acc / 1024);
    end
  endtask

  task automatic a_step();
    @(negedge clk);
    a_out_full = a_full_next;
    a_in_empty = (a_src.size() == 0) || (rand_empty && ($urandom_range(0, 1) == 1));
    a_in_dout  = (a_src.size() > 0) ? a_src[0] : 0;
    #1;
    cyc++;
    if (a_in_rd_en) begin
      check("pop_while_empty", a_in_empty, 0);
      if (a_src.size() > 0) begin
        model_pop(a_src.pop_front());
        last_pop_cyc = cyc;
      end
    end
    if (a_out_wr_en) begin
      a_got.push_back($signed(a_out_din));
      last_push_cyc = cyc;
    end
  endtask

  task automatic a_run_until_pushes(input int n, input int budget);
    int i;
    i = 0;
    while (a_got.size() < n && i < budget) begin
      a_step();
      i++;
    end
    check("push_count_in_budget", a_got.size(), n);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    a_in_empty  = 1'b1;
    b_in_empty  = 1'b1;
    a_full_next = 1'b0;
    a_out_full  = 1'b0;
    rand_empty  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [8];
    int   dc_exp [5];
    int   bp_wr, bp_busy_low, bp_din_bad, guard;
    int   got;
    bit   seen;

    vecs[0] = '{-1, 0};      vecs[1] = '{-2048, -2};
    vecs[2] = '{-1025, -1};  vecs[3] = '{1025, 1};
    vecs[4] = '{2047, 1};    vecs[5] = '{-3072, -3};
    vecs[6] = '{1023, 0};    vecs[7] = '{0, 0};
    dc_exp  = '{8192, 16384, 24576, 32768, 32768};

    // Reset state with a non-empty upstream FIFO
    @(negedge clk);
    a_in_empty = 1'b0;
    a_in_dout  = 32'd77;
    @(negedge clk);
    #1;
    check("reset_in_rd_en", a_in_rd_en, 0);
    check("reset_out_wr_en", a_out_wr_en, 0);
    check("reset_busy", a_busy, 0);
    check("reset_coeff_addr", a_coeff_addr, 0);
    check("reset_out_din", a_out_din, 0);

    // Impulse through the ramp coefficients
    do_reset();
    for (int k = 0; k < TAPS_A; k++) coeff_a[k] = k + 1;
    a_src = '{1024, 0, 0, 0, 0, 0, 0, 0};
    a_run_until_pushes(1, 200);
    if (a_got.size() > 0) check("impulse_out", a_got[0], 8);
    check("impulse_latency", last_push_cyc - last_pop_cyc, 33);
    repeat (60) a_step();
    check("impulse_single_push", a_got.size(), 1);

    // DC ramp-up to steady state
    do_reset();
    for (int k = 0; k < TAPS_A; k++) coeff_a[k] = 1024;
    for (int i = 0; i < 40; i++) a_src.push_back(1024);
    a_run_until_pushes(5, 400);
    for (int i = 0; i < 5; i++) begin
      if (i < a_got.size()) check($sformatf("dc_out_%0d", i), a_got[i], dc_exp[i]);
    end

    // Backpressure held in S_WRITE
    do_reset();
    for (int i = 0; i < 16; i++) a_src.push_back(1024);
    a_full_next = 1'b1;
    repeat (45) a_step();
    bp_wr = 0; bp_busy_low = 0; bp_din_bad = 0;
    repeat (100) begin
      a_step();
      if (a_out_wr_en) bp_wr++;
      if (!a_busy) bp_busy_low++;
      if ($signed(a_out_din) != 8192) bp_din_bad++;
    end
    check("bp_no_pop", a_src.size(), 8);
    check("bp_no_push", bp_wr, 0);
    check("bp_busy_low_cycles", bp_busy_low, 0);
    check("bp_din_unstable_cycles", bp_din_bad, 0);
    a_full_next = 1'b0;
    a_step();
    check("bp_release_push", a_out_wr_en, 1);
    check("bp_release_din", $signed(a_out_din), 8192);
    a_step();
    check("bp_back_in_load_pop", a_in_rd_en, 1);
    check("bp_back_in_load_busy", a_busy, 0);

    // Starvation with random in_empty, against the reference model
    do_reset();
    for (int k = 0; k < TAPS_A; k++) coeff_a[k] = ((k * 7) % 11) - 5;
    for (int i = 0; i < 48; i++) a_src.push_back(int'($urandom_range(0, 10000)) - 5000);
    rand_empty = 1'b1;
    a_run_until_pushes(6, 2000);
    check("starve_expected_count", a_exp.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < a_got.size() && i < a_exp.size())
        check($sformatf("starve_out_%0d", i), a_got[i], a_exp[i]);
    end

    // Reset in the middle of a MAC pass clears history and partial sum
    do_reset();
    for (int k = 0; k < TAPS_A; k++) coeff_a[k] = 1024;
    for (int i = 0; i < 16; i++) a_src.push_back(1024);
    guard = 0;
    do begin
      a_step();
      guard++;
    end while (!(a_busy && a_coeff_addr == 5'd15) && guard < 100);
    check("midmac_tap15_reached", a_coeff_addr, 15);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("midmac_reset_busy", a_busy, 0);
    check("midmac_reset_wr_en", a_out_wr_en, 0);
    rst = 1'b0;
    model_clear();
    for (int i = 0; i < 8; i++) a_src.push_back(1024);
    a_run_until_pushes(1, 200);
    if (a_got.size() > 0) check("midmac_next_out", a_got[0], 8192);

    // DECIM=1 truncation-toward-zero table
    coeff_b = '{1, 0, 0, 0};
    for (int i = 0; i < 8; i++) begin
      seen = 1'b0;
      got = 0;
      b_have = 1'b1;
      for (int c = 0; c < 20 && !seen; c++) begin
        @(negedge clk);
        b_in_dout  = vecs[i].sample;
        b_in_empty = !b_have;
        #1;
        if (b_in_rd_en) b_have = 1'b0;
        if (b_out_wr_en) begin
          seen = 1'b1;
          got  = $signed(b_out_din);
        end
      end
      check($sformatf("trunc_push_seen_%0d", i), seen, 1);
      check($sformatf("trunc_out_%0d", vecs[i].sample), got, vecs[i].expected);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fir_decim_sequencer.md
Name: fir_decim_sequencer

Overview:
Controller that time-shares one multiplier-accumulator across all taps of a decimating FIR stage in the FM demod/audio chain. It pulls quantized samples (fixed point, BITS fractional bits) from an upstream FIFO and keeps the TAPS-deep sample history. After every DECIM reads it sequences TAPS MAC cycles against an external coefficient ROM, dequantizes the sum and pushes one result into the downstream FIFO. The same block serves the audio decimator (DECIM=8) and, with DECIM=1, plain channel filters.

Parameters:
TAPS, 32, number of FIR taps (2..MAX_TAPS).
DECIM, 8, input samples consumed per output sample (1..TAPS).
DATA_WIDTH, 32, signed sample, coefficient and output width.
BITS, 10, fractional bits removed after accumulation.

Ports:
clock  in  1  system clock.
reset  in  1  synchronous, active-high reset.
in_dout  in  DATA_WIDTH  signed sample at upstream FIFO head.
in_empty  in  1  upstream FIFO empty.
in_rd_en  out  1  pop upstream FIFO this cycle.
coeff_addr  out  $clog2(TAPS)  coefficient ROM address.
coeff_data  in  DATA_WIDTH  signed coefficient, combinational from coeff_addr (same cycle).
out_full  in  1  downstream FIFO full.
out_wr_en  out  1  push out_din this cycle.
out_din  out  DATA_WIDTH  signed filtered sample.
busy  out  1  high in S_MAC and S_WRITE.

Behaviour:
- Reset (any state, including mid-MAC): state=S_LOAD, load_cnt=0, tap_cnt=0, acc=0, history[0..TAPS-1]=0, out_din=0. Reset forces in_rd_en, out_wr_en, busy and coeff_addr to 0. Any partial sum is discarded.
- in_rd_en = (state==S_LOAD) && !in_empty, combinational. out_wr_en = (state==S_WRITE) && !out_full, combinational. No pop or push occurs outside these conditions.
- S_LOAD: on each cycle with in_rd_en:
  - history[k] <= history[k-1] for k>=1, and history[0] <= in_dout. history[TAPS-1] is dropped.
  - load_cnt increments.
  - On the read with load_cnt==DECIM-1: load_cnt<=0, tap_cnt<=0, acc<=0, go S_MAC.
  - in_empty stalls the block with no state change.
- S_MAC: coeff_addr=tap_cnt (0 in other states). Product = coeff_data*history[tap_cnt], computed at 2*DATA_WIDTH signed, accumulated into a 2*DATA_WIDTH+$clog2(TAPS) acc.
  - tap_cnt < TAPS-1: acc <= acc+product, tap_cnt++.
  - tap_cnt == TAPS-1: out_din <= dequant(acc+product), go S_WRITE.
  - Takes exactly TAPS cycles and never stalls.
- dequant(x) = x / 2^BITS, truncating toward zero (integer-division semantics, not an arithmetic shift). The result keeps the low DATA_WIDTH bits, with no saturation.
- S_WRITE: out_din holds stable. On the out_wr_en cycle, go S_LOAD with load_cnt=0. out_full stalls indefinitely with no inputs consumed. S_WRITE and S_LOAD are distinct states, so a pop and a push never happen in the same cycle.
- Latency: the cycle after the DECIM-th pop enters S_MAC. With out_full low, out_wr_en asserts TAPS cycles after that. Best-case throughput is one output per DECIM+TAPS+1 cycles.
- History persists across outputs, which gives sliding-window FIR semantics. The first outputs after reset use the zero-initialised history.
- DECIM==1: every pop triggers a MAC pass.

Test Plan:
- Impulse: coeff[k]=k+1, samples 1024 then seven 0s, out_full=0 -> exactly one push, out_din=8 (history[7]·coeff[7]/1024). out_wr_en is asserted 33 cycles after the 8th in_rd_en.
- DC: all coeff=1024, continuous samples of 1024 -> out_din sequence 8192, 16384, 24576, 32768, 32768...
- Negative truncation: coeff[0]=1, all other coeff 0, DECIM=1, sample -1 -> out_din=0. Sample -2048 -> out_din=-2.
- Backpressure: hold out_full=1 for 100 cycles in S_WRITE -> out_wr_en=0, in_rd_en=0, out_din unchanged, busy=1. On release -> one push next cycle, then the block returns to S_LOAD.
- Starvation: in_empty toggles randomly -> outputs match a golden model computed from the same sample stream, and no pop occurs while in_empty=1.
- Reset at tap_cnt=15 in S_MAC -> next cycle busy=0, out_wr_en=0. The next output after 8 samples of 1024 (all coeff=1024) is 8192, confirming the history was cleared.
